// File: rtl/ga_pkg.sv
// Shared GA datapath constants and the fitness/chromosome pair type.
package ga_pkg;

  localparam int GA_FITNESS_WIDTH = 27;
  localparam int GA_CHROM_WIDTH   = 8;

  typedef struct packed {
    logic [GA_FITNESS_WIDTH-1:0] fit;
    logic [GA_CHROM_WIDTH-1:0]   chrom;
  } ga_cand_t;

endpackage

// File: rtl/get_best_k_if.sv
// Sample/result bundle between the fitness evaluators, the best-K tracker and the GA controller.
interface get_best_k_if
  import ga_pkg::*;
#(
  parameter int FITNESS_WIDTH = GA_FITNESS_WIDTH,
  parameter int CHROM_WIDTH   = GA_CHROM_WIDTH,
  parameter int LANES         = 2,
  parameter int DEPTH         = 4,
  parameter int STALL_WIDTH   = 8
);

  logic [LANES-1:0]               in_valid;
  logic [LANES*FITNESS_WIDTH-1:0] fitness;
  logic [LANES*CHROM_WIDTH-1:0]   chrom;
  logic                           gen_end;
  logic                           clear;

  logic [FITNESS_WIDTH-1:0]       best_fit;
  logic [CHROM_WIDTH-1:0]         best;
  logic [DEPTH*FITNESS_WIDTH-1:0] rank_fit;
  logic [DEPTH*CHROM_WIDTH-1:0]   rank_chrom;
  logic [DEPTH-1:0]               rank_valid;
  logic                           improved;
  logic                           gen_done;
  logic [STALL_WIDTH-1:0]         stall_gens;

  modport master (
    output in_valid, fitness, chrom, gen_end, clear,
    input  best_fit, best, rank_fit, rank_chrom, rank_valid, improved, gen_done, stall_gens
  );

  modport slave (
    input  in_valid, fitness, chrom, gen_end, clear,
    output best_fit, best, rank_fit, rank_chrom, rank_valid, improved, gen_done, stall_gens
  );

endinterface

// File: rtl/get_best_k_lane_min_tree.sv
// Combinational reduction of the valid lanes to the lowest-fitness candidate.
module lane_min_tree #(
  parameter int LANES         = 2,
  parameter int FITNESS_WIDTH = 27,
  parameter int CHROM_WIDTH   = 8
) (
  input  logic [LANES-1:0]               i_valid,
  input  logic [LANES*FITNESS_WIDTH-1:0] i_fitness,
  input  logic [LANES*CHROM_WIDTH-1:0]   i_chrom,
  output logic [FITNESS_WIDTH-1:0]       o_fit,
  output logic [CHROM_WIDTH-1:0]         o_chrom,
  output logic                           o_any
);

  logic [FITNESS_WIDTH-1:0] w_fit;
  logic [CHROM_WIDTH-1:0]   w_chrom;
  logic                     w_any;

  // Strict less-than while scanning upward keeps the lowest lane index on ties.
  always_comb begin
    w_fit   = {FITNESS_WIDTH{1'b1}};
    w_chrom = '0;
    w_any   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (i_valid[i] && (!w_any || (i_fitness[i*FITNESS_WIDTH +: FITNESS_WIDTH] < w_fit))) begin
        w_fit   = i_fitness[i*FITNESS_WIDTH +: FITNESS_WIDTH];
        w_chrom = i_chrom[i*CHROM_WIDTH +: CHROM_WIDTH];
        w_any   = 1'b1;
      end
    end
  end

  assign o_fit   = w_fit;
  assign o_chrom = w_chrom;
  assign o_any   = w_any;

endmodule

// File: rtl/get_best_k.sv
// Two-stage best-K tracker: lane reduction, then duplicate-free sorted insert with
// per-generation stagnation counting.
module get_best_k
  import ga_pkg::*;
#(
  parameter int FITNESS_WIDTH = GA_FITNESS_WIDTH,
  parameter int CHROM_WIDTH   = GA_CHROM_WIDTH,
  parameter int LANES         = 2,
  parameter int DEPTH         = 4,
  parameter int STALL_WIDTH   = 8
) (
  input logic         clk,
  input logic         reset,
  get_best_k_if.slave bus
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [FITNESS_WIDTH-1:0] FIT_WORST = {FITNESS_WIDTH{1'b1}};

  logic [FITNESS_WIDTH-1:0] w_min_fit;
  logic [CHROM_WIDTH-1:0]   w_min_chrom;
  logic                     w_min_any;

  logic                     r_s1_valid;
  logic                     r_s1_gen_end;
  logic [FITNESS_WIDTH-1:0] r_s1_fit;
  logic [CHROM_WIDTH-1:0]   r_s1_chrom;

  logic [FITNESS_WIDTH-1:0] r_fit   [DEPTH];
  logic [CHROM_WIDTH-1:0]   r_chrom [DEPTH];
  logic [DEPTH-1:0]         r_valid;
  logic                     r_improved;
  logic                     r_gen_done;
  logic                     r_gen_improved;
  logic [STALL_WIDTH-1:0]   r_stall;

  logic [FITNESS_WIDTH-1:0] w_up_fit    [DEPTH];
  logic [CHROM_WIDTH-1:0]   w_up_chrom  [DEPTH];
  logic [DEPTH-1:0]         w_up_valid;
  logic [FITNESS_WIDTH-1:0] w_nxt_fit   [DEPTH];
  logic [CHROM_WIDTH-1:0]   w_nxt_chrom [DEPTH];
  logic [DEPTH-1:0]         w_nxt_valid;
  logic                     w_nxt_improved;
  logic                     w_nxt_gen_done;
  logic                     w_nxt_gen_improved;
  logic [STALL_WIDTH-1:0]   w_nxt_stall;

  logic                     w_dup;
  logic                     w_accept;
  logic                     w_rank0;
  logic [PW-1:0]            w_pos;

  lane_min_tree #(
    .LANES        (LANES),
    .FITNESS_WIDTH(FITNESS_WIDTH),
    .CHROM_WIDTH  (CHROM_WIDTH)
  ) u_lane_min_tree (
    .i_valid  (bus.in_valid),
    .i_fitness(bus.fitness),
    .i_chrom  (bus.chrom),
    .o_fit    (w_min_fit),
    .o_chrom  (w_min_chrom),
    .o_any    (w_min_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_gen_end <= 1'b0;
      r_s1_fit     <= FIT_WORST;
      r_s1_chrom   <= '0;
    end else if (bus.clear) begin
      r_s1_valid   <= 1'b0;
      r_s1_gen_end <= 1'b0;
      r_s1_fit     <= FIT_WORST;
      r_s1_chrom   <= '0;
    end else begin
      r_s1_valid   <= w_min_any;
      r_s1_gen_end <= bus.gen_end;
      r_s1_fit     <= w_min_fit;
      r_s1_chrom   <= w_min_chrom;
    end
  end

  // Entry k's neighbour from rank k-1, used when the candidate lands above it.
  for (genvar k = 0; k < DEPTH; k++) begin : g_up
    if (k == 0) begin : g_top
      assign w_up_fit[k]   = r_fit[0];
      assign w_up_chrom[k] = r_chrom[0];
      assign w_up_valid[k] = r_valid[0];
    end else begin : g_rest
      assign w_up_fit[k]   = r_fit[k-1];
      assign w_up_chrom[k] = r_chrom[k-1];
      assign w_up_valid[k] = r_valid[k-1];
    end
  end

  // Counting entries with fitness <= f gives the insert slot since the list is sorted and contiguous.
  always_comb begin
    w_dup = 1'b0;
    w_pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[k]) begin
        if (r_chrom[k] == r_s1_chrom) w_dup = 1'b1;
        if (r_fit[k] <= r_s1_fit) w_pos = w_pos + PW'(1);
      end
    end
    w_accept = r_s1_valid && !w_dup && (w_pos < PW'(DEPTH));
    w_rank0  = w_accept && (w_pos == '0);
  end

  always_comb begin
    w_nxt_valid = r_valid;
    for (int k = 0; k < DEPTH; k++) begin
      w_nxt_fit[k]   = r_fit[k];
      w_nxt_chrom[k] = r_chrom[k];
    end
    if (bus.clear) begin
      w_nxt_valid = '0;
      for (int k = 0; k < DEPTH; k++) begin
        w_nxt_fit[k]   = FIT_WORST;
        w_nxt_chrom[k] = '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (PW'(k) == w_pos) begin
          w_nxt_fit[k]   = r_s1_fit;
          w_nxt_chrom[k] = r_s1_chrom;
          w_nxt_valid[k] = 1'b1;
        end else if (PW'(k) > w_pos) begin
          w_nxt_fit[k]   = w_up_fit[k];
          w_nxt_chrom[k] = w_up_chrom[k];
          w_nxt_valid[k] = w_up_valid[k];
        end
      end
    end
  end

  // A same-cycle rank-0 insert counts toward the generation that is closing.
  always_comb begin
    w_nxt_improved     = w_rank0;
    w_nxt_gen_done     = r_s1_gen_end;
    w_nxt_gen_improved = r_gen_improved | w_rank0;
    w_nxt_stall        = r_stall;
    if (bus.clear) begin
      w_nxt_improved     = 1'b0;
      w_nxt_gen_done     = 1'b0;
      w_nxt_gen_improved = 1'b0;
      w_nxt_stall        = '0;
    end else if (r_s1_gen_end) begin
      w_nxt_gen_improved = 1'b0;
      if (r_gen_improved || w_rank0) begin
        w_nxt_stall = '0;
      end else if (r_stall != {STALL_WIDTH{1'b1}}) begin
        w_nxt_stall = r_stall + STALL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_fit[k]   <= FIT_WORST;
        r_chrom[k] <= '0;
      end
      r_valid        <= '0;
      r_improved     <= 1'b0;
      r_gen_done     <= 1'b0;
      r_gen_improved <= 1'b0;
      r_stall        <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        r_fit[k]   <= w_nxt_fit[k];
        r_chrom[k] <= w_nxt_chrom[k];
      end
      r_valid        <= w_nxt_valid;
      r_improved     <= w_nxt_improved;
      r_gen_done     <= w_nxt_gen_done;
      r_gen_improved <= w_nxt_gen_improved;
      r_stall        <= w_nxt_stall;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_pack
    assign bus.rank_fit[k*FITNESS_WIDTH +: FITNESS_WIDTH] = r_fit[k];
    assign bus.rank_chrom[k*CHROM_WIDTH +: CHROM_WIDTH]   = r_chrom[k];
  end

  assign bus.rank_valid = r_valid;
  assign bus.best_fit   = r_fit[0];
  assign bus.best       = r_chrom[0];
  assign bus.improved   = r_improved;
  assign bus.gen_done   = r_gen_done;
  assign bus.stall_gens = r_stall;

endmodule

// File: tb/tb_get_best_k.sv
// Bench for get_best_k: vector table plus corner sequences, with expectations queued
// when a cycle is driven and compared two edges later.
module tb_get_best_k;
  import ga_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int FW    = GA_FITNESS_WIDTH;
  localparam int CW    = GA_CHROM_WIDTH;
  localparam int SW    = 8;
  localparam int NA    = -1;
  localparam logic [FW-1:0] WORST = {FW{1'b1}};

  typedef struct {
    int                  tag;
    logic [LANES-1:0]    valid;
    ga_cand_t            lane0;
    ga_cand_t            lane1;
    logic                genEnd;
    logic                clr;
    logic [3:0]          chk;
    logic [DEPTH*FW-1:0] expFit;
    logic [DEPTH*CW-1:0] expChrom;
    logic [DEPTH-1:0]    expValid;
    logic                expImproved;
    logic                expGenDone;
    logic [SW-1:0]       expStall;
  } vec_t;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  vec_t tbl [24];
  vec_t sb [$];

  get_best_k_if #(
    .FITNESS_WIDTH(FW), .CHROM_WIDTH(CW), .LANES(LANES), .DEPTH(DEPTH), .STALL_WIDTH(SW)
  ) bus ();

  get_best_k #(
    .FITNESS_WIDTH(FW), .CHROM_WIDTH(CW), .LANES(LANES), .DEPTH(DEPTH), .STALL_WIDTH(SW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [FW-1:0] toFit(input int e);
    return (e < 0) ? WORST : FW'(e);
  endfunction

  function automatic vec_t mkVec(input logic [1:0] v, input int f0, input int c0, input int f1,
                                 input int c1, input logic ge, input logic clr, input int e0,
                                 input int e1, input int e2, input int e3, input logic [31:0] ch,
                                 input logic [3:0] rv, input logic imp, input logic gd, input int st);
    vec_t r;
    r.tag         = 0;
    r.valid       = v;
    r.lane0.fit   = FW'(f0);
    r.lane0.chrom = CW'(c0);
    r.lane1.fit   = FW'(f1);
    r.lane1.chrom = CW'(c1);
    r.genEnd      = ge;
    r.clr         = clr;
    r.chk         = 4'hF;
    r.expFit      = {toFit(e3), toFit(e2), toFit(e1), toFit(e0)};
    r.expChrom    = ch;
    r.expValid    = rv;
    r.expImproved = imp;
    r.expGenDone  = gd;
    r.expStall    = SW'(st);
    return r;
  endfunction

  task automatic cmp(input string nm, input int tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, tag, act, exp);
  endtask

  task automatic checkOutput(input vec_t e);
    if (e.chk[0]) begin
      cmp("rank_fit", e.tag, 128'(bus.rank_fit), 128'(e.expFit));
      cmp("rank_chrom", e.tag, 128'(bus.rank_chrom), 128'(e.expChrom));
      cmp("rank_valid", e.tag, 128'(bus.rank_valid), 128'(e.expValid));
      cmp("best_fit", e.tag, 128'(bus.best_fit), 128'(e.expFit[FW-1:0]));
      cmp("best", e.tag, 128'(bus.best), 128'(e.expChrom[CW-1:0]));
    end
    if (e.chk[1]) cmp("improved", e.tag, 128'(bus.improved), 128'(e.expImproved));
    if (e.chk[2]) cmp("gen_done", e.tag, 128'(bus.gen_done), 128'(e.expGenDone));
    if (e.chk[3]) cmp("stall_gens", e.tag, 128'(bus.stall_gens), 128'(e.expStall));
  endtask

  // Each call drives one cycle; the entry queued two calls earlier is then due.
  task automatic applyStimulus(input vec_t v);
    vec_t e;
    bus.in_valid = v.valid;
    bus.fitness  = {v.lane1.fit, v.lane0.fit};
    bus.chrom    = {v.lane1.chrom, v.lane0.chrom};
    bus.gen_end  = v.genEnd;
    bus.clear    = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  endtask

  initial begin
    vec_t v;
    passed = 0;
    total  = 0;

    tbl[0]  = mkVec(2'b11, 10, 'hA1, 10, 'hB2, 0, 0, 10, NA, NA, NA, 32'h000000A1, 4'b0001, 1, 0, 0);
    tbl[1]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 10, NA, NA, NA, 32'h000000A1, 4'b0001, 0, 0, 0);
    tbl[2]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 0, 0);
    tbl[3]  = mkVec(2'b00, 0, 0, 0, 0, 0, 1, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 0, 0);
    tbl[4]  = mkVec(2'b01, 50, 1, 0, 0, 0, 0, 50, NA, NA, NA, 32'h00000001, 4'b0001, 1, 0, 0);
    tbl[5]  = mkVec(2'b01, 20, 2, 0, 0, 0, 0, 20, 50, NA, NA, 32'h00000102, 4'b0011, 1, 0, 0);
    tbl[6]  = mkVec(2'b01, 40, 3, 0, 0, 0, 0, 20, 40, 50, NA, 32'h00010302, 4'b0111, 0, 0, 0);
    tbl[7]  = mkVec(2'b01, 30, 4, 0, 0, 0, 0, 20, 30, 40, 50, 32'h01030402, 4'b1111, 0, 0, 0);
    tbl[8]  = mkVec(2'b01, 10, 5, 0, 0, 0, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 1, 0, 0);
    tbl[9]  = mkVec(2'b01, 40, 9, 0, 0, 0, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 0, 0, 0);
    tbl[10] = mkVec(2'b01, 15, 2, 0, 0, 0, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 0, 0, 0);
    tbl[11] = mkVec(2'b00, 0, 0, 0, 0, 1, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 0, 1, 0);
    tbl[12] = mkVec(2'b00, 0, 0, 0, 0, 1, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 0, 1, 1);
    tbl[13] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 0, 0, 1);
    tbl[14] = mkVec(2'b00, 0, 0, 0, 0, 1, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 0, 1, 2);
    tbl[15] = mkVec(2'b00, 0, 0, 0, 0, 1, 0, 10, 20, 30, 40, 32'h03040205, 4'b1111, 0, 1, 3);
    tbl[16] = mkVec(2'b01, 5, 7, 0, 0, 1, 0, 5, 10, 20, 30, 32'h04020507, 4'b1111, 1, 1, 0);
    tbl[17] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 5, 10, 20, 30, 32'h04020507, 4'b1111, 0, 0, 0);
    tbl[18] = mkVec(2'b10, 0, 0, 25, 8, 1, 0, 5, 10, 20, 25, 32'h08020507, 4'b1111, 0, 1, 1);
    tbl[19] = mkVec(2'b11, 3, 'h20, 2, 'h21, 0, 0, 2, 5, 10, 20, 32'h02050721, 4'b1111, 1, 0, 1);
    tbl[20] = mkVec(2'b11, 4, 'h30, 4, 'h31, 0, 0, 2, 4, 5, 10, 32'h05073021, 4'b1111, 0, 0, 1);
    tbl[21] = mkVec(2'b11, 2, 'h40, 1, 'h21, 0, 0, 2, 4, 5, 10, 32'h05073021, 4'b1111, 0, 0, 1);
    tbl[22] = mkVec(2'b01, 2, 'h41, 0, 0, 0, 0, 2, 2, 4, 5, 32'h07304121, 4'b1111, 0, 0, 1);
    tbl[23] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 2, 2, 4, 5, 32'h07304121, 4'b1111, 0, 0, 1);

    reset        = 1'b0;
    bus.in_valid = '0;
    bus.fitness  = '0;
    bus.chrom    = '0;
    bus.gen_end  = 1'b0;
    bus.clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    cmp("reset best_fit", -1, 128'(bus.best_fit), 128'(WORST));
    cmp("reset best", -1, 128'(bus.best), 128'(0));
    cmp("reset rank_valid", -1, 128'(bus.rank_valid), 128'(0));
    cmp("reset stall_gens", -1, 128'(bus.stall_gens), 128'(0));
    cmp("reset gen_done", -1, 128'(bus.gen_done), 128'(0));
    cmp("reset improved", -1, 128'(bus.improved), 128'(0));

    for (int i = 0; i < 24; i++) begin
      tbl[i].tag = i;
      applyStimulus(tbl[i]);
    end

    // Rank 0 was improved just before, so the first of these resets the count to 0.
    for (int k = 0; k < 300; k++) begin
      v             = mkVec(2'b00, 0, 0, 0, 0, 1, 0, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 1, 0);
      v.tag         = 100 + k;
      v.chk         = 4'b1110;
      v.expStall    = (k > 255) ? SW'(255) : SW'(k);
      applyStimulus(v);
    end

    v = mkVec(2'b00, 0, 0, 0, 0, 0, 0, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 0, 0);
    v.tag = 400;
    applyStimulus(v);
    v = mkVec(2'b00, 0, 0, 0, 0, 0, 1, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 0, 0);
    v.tag = 401;
    applyStimulus(v);
    v = mkVec(2'b01, 1, 'h33, 0, 0, 1, 0, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 0, 0);
    v.tag = 402;
    applyStimulus(v);
    v = mkVec(2'b00, 0, 0, 0, 0, 0, 1, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 0, 0);
    v.tag = 403;
    applyStimulus(v);
    v = mkVec(2'b00, 0, 0, 0, 0, 0, 0, NA, NA, NA, NA, 32'h0, 4'b0000, 0, 0, 0);
    v.tag = 404;
    applyStimulus(v);

    v = mkVec(2'b01, 100, 'h51, 0, 0, 0, 0, 100, NA, NA, NA, 32'h00000051, 4'b0001, 1, 0, 0);
    v.tag = 410;
    applyStimulus(v);
    v = mkVec(2'b01, 200, 'h52, 0, 0, 0, 0, 100, 200, NA, NA, 32'h00005251, 4'b0011, 0, 0, 0);
    v.tag = 411;
    applyStimulus(v);
    v = mkVec(2'b01, 300, 'h53, 0, 0, 0, 0, 100, 200, 300, NA, 32'h00535251, 4'b0111, 0, 0, 0);
    v.tag = 412;
    applyStimulus(v);
    v = mkVec(2'b01, 400, 'h54, 0, 0, 0, 0, 100, 200, 300, 400, 32'h54535251, 4'b1111, 0, 0, 0);
    v.tag = 413;
    applyStimulus(v);
    v = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 100, 200, 300, 400, 32'h54535251, 4'b1111, 0, 0, 0);
    v.tag = 414;
    applyStimulus(v);
    v.chk = 4'b0000;
    v.tag = 415;
    applyStimulus(v);
    sb.delete();

    // Reset asserted mid-cycle must clear the full list before the next rising edge.
    #3 reset = 1'b0;
    #1;
    cmp("async rank_valid", 500, 128'(bus.rank_valid), 128'(0));
    cmp("async best_fit", 500, 128'(bus.best_fit), 128'(WORST));
    cmp("async best", 500, 128'(bus.best), 128'(0));
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    cmp("post-reset rank_valid", 501, 128'(bus.rank_valid), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/get_best_k.md
# get_best_k

Pipelined multi-lane best-K tracker for the GA datapath. Each cycle it accepts up to LANES scored chromosomes and reduces them to the lowest-fitness candidate. That candidate is inserted into a sorted, duplicate-free list of the DEPTH best chromosomes seen so far. The block sits after the fitness evaluators, reports per-generation stagnation to the GA controller, and replaces the fixed two-lane single-best tracker.

## Interface
- FITNESS_WIDTH, 27, fitness width; lower fitness is better.
- CHROM_WIDTH, 8, chromosome width.
- LANES, 2, parallel input lanes (≥1).
- DEPTH, 4, entries in the ranked list (≥1).
- STALL_WIDTH, 8, width of the stagnation counter.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  LANES  per-lane sample valid.
- fitness  in  LANES*FITNESS_WIDTH  lane i at [i*FITNESS_WIDTH +: FITNESS_WIDTH].
- chrom  in  LANES*CHROM_WIDTH  lane i at [i*CHROM_WIDTH +: CHROM_WIDTH].
- gen_end  in  1  marks the last sample cycle of a generation; may coincide with in_valid.
- clear  in  1  synchronous clear of the list, counters and pipeline.
- best_fit  out  FITNESS_WIDTH  fitness of rank 0.
- best  out  CHROM_WIDTH  chromosome of rank 0.
- rank_fit  out  DEPTH*FITNESS_WIDTH  sorted fitnesses, rank 0 in the LSBs.
- rank_chrom  out  DEPTH*CHROM_WIDTH  chromosomes, same ordering as rank_fit.
- rank_valid  out  DEPTH  entry-valid flags; always a contiguous run of ones from rank 0.
- improved  out  1  one-cycle pulse when rank 0 is replaced.
- gen_done  out  1  one-cycle pulse when a generation has been fully absorbed.
- stall_gens  out  STALL_WIDTH  generations since the last rank-0 improvement; saturates at all ones.

## Operation
- Reset and clear values:
  - rank_fit and best_fit: all ones.
  - rank_chrom and best: 0.
  - rank_valid: 0.
  - improved, gen_done and stall_gens: 0.
  - Stage-1 valid and the internal gen_improved flag: 0.
- Stage 1 (lane reduction):
  - Selects the minimum fitness among the lanes with in_valid set.
  - On equal fitness, the lowest lane index wins.
  - The selection is registered together with a "any lane valid" bit and the gen_end bit.
- Stage 2 (insert), for candidate (f, c):
  - If c equals the chromosome of any valid entry, the candidate is discarded.
  - Otherwise p = number of valid entries with fitness ≤ f, so existing entries win ties.
  - If p = DEPTH, the candidate is discarded.
  - Otherwise entries p..DEPTH-2 shift down one rank, the entry at DEPTH-1 drops, and (f, c) is written at rank p with valid set.
- Rank-0 improvement: when p = 0 and the insert is accepted, improved pulses and gen_improved is set.
- Generation end, when stage 2 sees gen_end:
  - gen_done pulses.
  - If gen_improved is set, including from a same-cycle insert, stall_gens is set to 0.
  - Otherwise stall_gens increments, saturating at 2^STALL_WIDTH − 1.
  - gen_improved is cleared.
- Only one candidate per cycle enters the list. Lanes that lose the stage-1 reduction are not considered, by design.

## Timing
- Latency: a sample presented in cycle N is reflected on all outputs after edge N+2. improved pulses in cycle N+2.
- gen_end in cycle N produces gen_done in cycle N+2 and covers every sample presented in cycles ≤ N.
- Throughput: one sample cycle per clock with no backpressure; there is no ready signal.
- Asynchronous reset assertion forces all registers to their reset values immediately, independent of clk.
- clear in cycle N:
  - Outputs hold their reset values from edge N+1.
  - Inputs presented in cycle N and the sample in stage 1 are discarded, and no gen_done is produced for them.
  - Pending gen_end bits are dropped.
- All-lanes-invalid cycle with gen_end set: gen_done is still produced.
- Empty list: the first accepted candidate lands at rank 0 and improved pulses.

## Structure
- Shared package ga_pkg holds:
  - default width constants GA_FITNESS_WIDTH = 27 and GA_CHROM_WIDTH = 8;
  - the bench-side struct of a fitness/chromosome pair at those defaults.
- The fitness worst value is derived in-block as all ones of FITNESS_WIDTH.
- One natural sub-module: lane_min_tree.
  - Parametrised LANES-input reduction with lowest-index tie-break.
  - Outputs the winning fitness, chromosome and any-valid bit.
  - Combinational; the caller registers its outputs.

## Test plan
1. Reset deasserted with LANES=2, DEPTH=4 -> best_fit=0x7FFFFFF, rank_valid=4'b0000, stall_gens=0, gen_done=0.
2. Same cycle, lane0 (10, 0xA1) and lane1 (10, 0xB2) -> two cycles later best=0xA1, best_fit=10, improved=1 for one cycle.
3. Lane0-only fitness 50, 20, 40, 30, 10 with chromosomes 1..5 -> rank_fit=10,20,30,40, rank_chrom=5,2,4,3, rank_valid=4'b1111, improved pulses for 50, 20 and 10 only.
4. With list from scenario 3, feed (40, 0x09) then (15, 0x02) -> both discarded, list unchanged, improved stays 0.
5. Stagnation: three gen_end pulses with no better sample -> stall_gens 1, 2, 3. Then (5, 0x07) with gen_end in the same cycle -> stall_gens=0. 300 non-improving generations -> stall_gens=255.
6. Cancelled sample: (1, 0x33) in cycle N, clear in N+1 -> rank_valid stays 0. Asynchronous reset asserted mid-cycle with the list full -> rank_valid=0 before the next clk edge.
